// File: rtl/vgachargen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_pkg
// Purpose  : Shared constants, control codes, console FSM state type and the
//            byte-lane merge helper used by the APB console master.
// Revision : 1.0 - initial release
// ============================================================================
package vgachargen_pkg;

  localparam int unsigned SCREEN_COLS  = 80;
  localparam int unsigned SCREEN_ROWS  = 30;
  localparam int unsigned CH_MAP_WORDS = 600;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_SETUP   = 3'd1,
    ST_RD_ACCESS  = 3'd2,
    ST_WR_SETUP   = 3'd3,
    ST_WR_ACCESS  = 3'd4,
    ST_CLR_SETUP  = 3'd5,
    ST_CLR_ACCESS = 3'd6
  } console_state_t;

  // Replace one byte lane of a char-map word; lane 0 is bits [7:0].
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  ch);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = ch;
      2'd1:    r[15:8]  = ch;
      2'd2:    r[23:16] = ch;
      default: r[31:24] = ch;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_console_cursor.sv
`default_nettype none
// ============================================================================
// Module   : vga_console_cursor
// Purpose  : Text cursor (row/col) with advance/newline/CR/BS/home commands,
//            plus the char-map word index and byte lane of the current cell.
// Revision : 1.0 - initial release
// ============================================================================
module vga_console_cursor #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              adv_i,
  input  logic              nl_i,
  input  logic              cr_i,
  input  logic              bs_i,
  input  logic              home_i,
  output logic [6:0]        col_o,
  output logic [4:0]        row_o,
  output logic [ADDR_W-1:0] word_o,
  output logic [1:0]        lane_o
);

  localparam logic [6:0] LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW      = 5'(ROWS - 1);
  localparam logic [7:0] WORDS_PER_ROW = 8'(COLS / 4);

  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        row_inc;
  logic [ADDR_W-1:0] row_base;

  // Next row with wrap to the top; there is no scrolling.
  assign row_inc = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  // Cursor next-state; commands are mutually exclusive in practice, home wins.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home_i) begin
      col_d = 7'd0;
      row_d = 5'd0;
    end else if (adv_i) begin
      if (col_q == LAST_COL) begin
        col_d = 7'd0;
        row_d = row_inc;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (nl_i) begin
      col_d = 7'd0;
      row_d = row_inc;
    end else if (cr_i) begin
      col_d = 7'd0;
    end else if (bs_i) begin
      if (col_q != 7'd0) begin
        col_d = col_q - 7'd1;
      end else if (row_q != 5'd0) begin
        col_d = LAST_COL;
        row_d = row_q - 5'd1;
      end
    end
  end

  // Cursor registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= 7'd0;
      row_q <= 5'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // row * (COLS/4) as a sum of constant shifts of row (no multiplier).
  always_comb begin
    row_base = '0;
    for (int b = 0; b < 8; b++) begin
      if (WORDS_PER_ROW[b]) begin
        row_base = row_base + (ADDR_W'(row_q) << b);
      end
    end
  end

  assign word_o = row_base + ADDR_W'(col_q[6:2]);
  assign lane_o = col_q[1:0];
  assign col_o  = col_q;
  assign row_o  = row_q;

endmodule
`default_nettype wire

// File: rtl/apb_vga_console.sv
`default_nettype none
// ============================================================================
// Module   : apb_vga_console
// Purpose  : APB master feeding the vgachargen char map from a byte stream.
//            Printable bytes become read-modify-write of the cell's word,
//            LF/CR/BS move the cursor, FF blanks the whole map.
// Revision : 1.0 - initial release
// ============================================================================
module apb_vga_console
  import vgachargen_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 14,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned COLS           = SCREEN_COLS,
  parameter int unsigned ROWS           = SCREEN_ROWS,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [7:0]                char_data_i,
  input  logic                      char_valid_i,
  output logic                      char_ready_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [6:0]                cursor_col_o,
  output logic [4:0]                cursor_row_o
);

  localparam logic [APB_ADDR_WIDTH-1:0] LAST_WORD   = APB_ADDR_WIDTH'(COLS * ROWS / 4 - 1);
  localparam logic [31:0]               BLANK_WORD  = {4{BLANK_CHAR}};
  localparam console_state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLR_SETUP : ST_IDLE;

  console_state_t            state_q, state_d;
  logic                      run_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [7:0]                char_q, char_d;
  logic [APB_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                      err_q, err_d;

  logic                      cur_adv, cur_nl, cur_cr, cur_bs, cur_home;
  logic [APB_ADDR_WIDTH-1:0] cell_word;
  logic [1:0]                cell_lane;
  logic                      is_print;
  logic                      in_access;

  assign is_print  = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);
  assign in_access = (state_q == ST_RD_ACCESS) || (state_q == ST_WR_ACCESS) ||
                     (state_q == ST_CLR_ACCESS);

  vga_console_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (APB_ADDR_WIDTH)
  ) u_cursor (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .adv_i  (cur_adv),
    .nl_i   (cur_nl),
    .cr_i   (cur_cr),
    .bs_i   (cur_bs),
    .home_i (cur_home),
    .col_o  (cursor_col_o),
    .row_o  (cursor_row_o),
    .word_o (cell_word),
    .lane_o (cell_lane)
  );

  // run_q holds every output low for the first cycle after reset release,
  // so a power-on clear still starts with a visible SETUP cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // State and APB datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RESET_STATE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      char_q    <= 8'd0;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      char_q    <= char_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state, bus field updates and cursor commands.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    char_d    = char_q;
    clr_cnt_d = clr_cnt_q;
    err_d     = err_q;
    cur_adv   = 1'b0;
    cur_nl    = 1'b0;
    cur_cr    = 1'b0;
    cur_bs    = 1'b0;
    cur_home  = 1'b0;

    if (!run_q) begin
      // Prime the bus fields for the power-on clear's first SETUP.
      if (state_q == ST_CLR_SETUP) begin
        paddr_d   = '0;
        pwdata_d  = BLANK_WORD;
        pwrite_d  = 1'b1;
        clr_cnt_d = '0;
      end
    end else begin
      if (in_access && apb_pready_i && apb_pslverr_i) begin
        err_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (char_valid_i) begin
            char_d = char_data_i;
            if (is_print) begin
              state_d  = ST_RD_SETUP;
              paddr_d  = cell_word;
              pwrite_d = 1'b0;
            end else if (char_data_i == CHAR_FF) begin
              state_d   = ST_CLR_SETUP;
              paddr_d   = '0;
              pwdata_d  = BLANK_WORD;
              pwrite_d  = 1'b1;
              clr_cnt_d = '0;
            end else if (char_data_i == CHAR_LF) begin
              cur_nl = 1'b1;
            end else if (char_data_i == CHAR_CR) begin
              cur_cr = 1'b1;
            end else if (char_data_i == CHAR_BS) begin
              cur_bs = 1'b1;
            end
          end
        end
        ST_RD_SETUP:  state_d = ST_RD_ACCESS;
        ST_RD_ACCESS: begin
          if (apb_pready_i) begin
            state_d  = ST_WR_SETUP;
            pwdata_d = merge_lane(apb_prdata_i, cell_lane, char_q);
            pwrite_d = 1'b1;
          end
        end
        ST_WR_SETUP:  state_d = ST_WR_ACCESS;
        ST_WR_ACCESS: begin
          if (apb_pready_i) begin
            state_d = ST_IDLE;
            cur_adv = 1'b1;
          end
        end
        ST_CLR_SETUP: state_d = ST_CLR_ACCESS;
        ST_CLR_ACCESS: begin
          if (apb_pready_i) begin
            if (clr_cnt_q == LAST_WORD) begin
              state_d  = ST_IDLE;
              cur_home = 1'b1;
            end else begin
              state_d   = ST_CLR_SETUP;
              clr_cnt_d = clr_cnt_q + 1'b1;
              paddr_d   = clr_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake/select outputs decode the state directly so reset drops them at once.
  assign char_ready_o  = run_q && (state_q == ST_IDLE);
  assign busy_o        = run_q && (state_q != ST_IDLE);
  assign apb_psel_o    = busy_o;
  assign apb_penable_o = run_q && in_access;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pwrite_o  = pwrite_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_vga_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_vga_console
// Purpose  : Self-checking bench for apb_vga_console: expected APB transfers
//            are queued by the stimulus and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_vga_console;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  char_data = 8'd0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [13:0] apb_paddr;
  logic [31:0] apb_pwdata;
  logic        apb_pwrite, apb_psel, apb_penable;
  logic [31:0] apb_prdata;
  logic        apb_pready = 1'b0;
  logic        apb_pslverr = 1'b0;
  logic        busy, err;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  typedef struct {
    logic [13:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 2;
  logic [31:0] rd_word  = 32'd0;
  bit          err_on_write = 1'b0;
  int          acc_cnt  = 0;

  always #5 clk = ~clk;

  assign apb_prdata = rd_word;

  apb_vga_console dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .char_data_i   (char_data),
    .char_valid_i  (char_valid),
    .char_ready_o  (char_ready),
    .apb_paddr_o   (apb_paddr),
    .apb_pwdata_o  (apb_pwdata),
    .apb_pwrite_o  (apb_pwrite),
    .apb_psel_o    (apb_psel),
    .apb_penable_o (apb_penable),
    .apb_prdata_i  (apb_prdata),
    .apb_pready_i  (apb_pready),
    .apb_pslverr_i (apb_pslverr),
    .busy_o        (busy),
    .err_o         (err),
    .cursor_col_o  (cur_col),
    .cursor_row_o  (cur_row)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cur(input string name, input int r, input int c);
    check(name, {20'd0, cur_row, cur_col}, {20'd0, 5'(r), 7'(c)});
  endtask

  task automatic push(input int a, input logic w, input logic [31:0] d);
    xfer_t e;
    e.addr = 14'(a);
    e.wr   = w;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, char_ready}, 32'd1);
    char_data  = b;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(char_ready && !busy) && n < max_cycles);
    check(name, {30'd0, char_ready, busy}, 32'd2);
  endtask

  // Printable byte with a known read word and hand-computed write word.
  task automatic print_char(input logic [7:0] b, input logic [31:0] rd,
                            input int addr, input logic [31:0] wexp);
    rd_word = rd;
    push(addr, 1'b0, 32'd0);
    push(addr, 1'b1, wexp);
    send(b);
    wait_idle(200, "rmw_idle");
  endtask

  // APB slave: pready rises 'lat' cycles after penable.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (apb_psel && apb_penable) begin
        acc_cnt++;
        apb_pready  = (acc_cnt > lat);
        apb_pslverr = apb_pready && err_on_write && apb_pwrite;
      end else begin
        acc_cnt     = 0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
      end
    end
  end

  // Monitor: every completed transfer must match the head of the queue.
  initial begin : monitor
    xfer_t e;
    forever begin
      @(negedge clk);
      if (rstn && apb_psel && apb_penable && apb_pready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: actual addr 0x%0h required no transfer", apb_paddr);
        end else begin
          e = exp_q.pop_front();
          check("xfer_addr", {18'd0, apb_paddr}, {18'd0, e.addr});
          check("xfer_dir", {31'd0, apb_pwrite}, {31'd0, e.wr});
          if (e.wr) check("xfer_wdata", apb_pwdata, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] tab_b [7] = '{32'h20202030, 32'h20203120, 32'h20322020, 32'h33202020,
                             32'h20202034, 32'h20203520, 32'h20362020};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'd0, apb_psel, apb_penable, char_ready, busy, err}, 32'd0);
    check("rst_bus", {17'd0, apb_pwrite, apb_paddr}, 32'd0);
    check("rst_pwdata", apb_pwdata, 32'd0);
    chk_cur("rst_cursor", 0, 0);

    // Power-on clear
    for (int i = 0; i < 600; i++) push(i, 1'b1, 32'h20202020);
    lat  = 2;
    rstn = 1'b1;
    wait_idle(4000, "clear_idle");
    check("clear_all_seen", 32'(exp_q.size()), 32'd0);
    chk_cur("clear_cursor", 0, 0);

    // First character at home; first psel one cycle after accept
    rd_word = 32'h20202020;
    push(0, 1'b0, 32'd0);
    push(0, 1'b1, 32'h20202041);
    send(8'h41);
    check("first_psel", {29'd0, apb_psel, apb_penable, apb_pwrite}, 32'd4);
    check("rd_setup_addr", {18'd0, apb_paddr}, 32'd0);
    chk_cur("mid_rmw_cursor", 0, 0);
    wait_idle(200, "a_idle");
    chk_cur("a_cursor", 0, 1);

    // Walk to (2,7) and write a lane-3 cell
    send(8'h0A);
    send(8'h0A);
    chk_cur("lf2_cursor", 2, 0);
    for (int c = 0; c < 7; c++) print_char(8'(8'h30 + c), 32'h20202020, 40 + c / 4, tab_b[c]);
    chk_cur("b_pre_cursor", 2, 7);
    print_char(8'h5A, 32'h11223344, 41, 32'h5A223344);
    chk_cur("b_cursor", 2, 8);

    // Fill row 29 to the last column, then wrap to home
    repeat (27) send(8'h0A);
    chk_cur("row29_cursor", 29, 0);
    for (int c = 0; c < 79; c++) print_char(8'h2E, 32'd0, 580 + c / 4, 32'h2E << (8 * (c % 4)));
    chk_cur("last_cell_cursor", 29, 79);
    print_char(8'h42, 32'h20202020, 599, 32'h42202020);
    chk_cur("wrap_cursor", 0, 0);

    // Control codes: no bus traffic, cursor moves on accept
    repeat (3) send(8'h0A);
    for (int c = 0; c < 5; c++) print_char(8'h2D, 32'd0, 60 + c / 4, 32'h2D << (8 * (c % 4)));
    chk_cur("pre_lf_cursor", 3, 5);
    send(8'h0A);
    check("lf_no_psel", {29'd0, apb_psel, busy, char_ready}, 32'd1);
    chk_cur("lf_cursor", 4, 0);
    send(8'h08);
    chk_cur("bs_col0_cursor", 3, 79);
    send(8'h0D);
    chk_cur("cr_cursor", 3, 0);
    repeat (27) send(8'h0A);
    chk_cur("lf_wrap_cursor", 0, 0);
    send(8'h08);
    chk_cur("bs_home_cursor", 0, 0);
    send(8'h07);
    check("ignored_no_psel", {30'd0, apb_psel, char_ready}, 32'd1);
    chk_cur("ignored_cursor", 0, 0);

    // Stalled read: bus frozen, no byte accepted
    lat     = 10;
    rd_word = 32'h20202020;
    push(0, 1'b0, 32'd0);
    push(0, 1'b1, 32'h20202043);
    send(8'h43);
    char_data  = 8'h0A;
    char_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_bus", {14'd0, apb_psel, apb_penable, char_ready, apb_pready, apb_paddr},
            {14'd0, 4'b1100, 14'd0});
    end
    char_valid = 1'b0;
    wait_idle(200, "stall_idle");
    chk_cur("stall_cursor", 0, 1);

    // Slave error on a write: sticky err_o
    lat          = 2;
    err_on_write = 1'b1;
    check("err_before", {31'd0, err}, 32'd0);
    rd_word = 32'h20202043;
    push(0, 1'b0, 32'd0);
    push(0, 1'b1, 32'h20204443);
    send(8'h44);
    for (int n = 0; n < 100 && !(apb_psel && apb_penable && apb_pready && apb_pwrite); n++)
      @(negedge clk);
    @(posedge clk);
    #1 check("err_set", {31'd0, err}, 32'd1);
    err_on_write = 1'b0;
    wait_idle(200, "err_idle");
    chk_cur("err_cursor", 0, 2);
    print_char(8'h45, 32'h20204443, 0, 32'h20454443);
    check("err_sticky", {31'd0, err}, 32'd1);
    chk_cur("post_err_cursor", 0, 3);

    // Reset pulse during a read access
    lat = 10;
    send(8'h46);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_access", {30'd0, apb_psel, apb_penable}, 32'd3);
    rstn = 1'b0;
    #1;
    check("rst_abort", {28'd0, apb_psel, apb_penable, err, char_ready}, 32'd0);
    chk_cur("rst_abort_cursor", 0, 0);
    for (int i = 0; i < 600; i++) push(i, 1'b1, 32'h20202020);
    lat = 0;
    @(negedge clk);
    rstn = 1'b1;
    wait_idle(3000, "reclear_idle");
    check("reclear_all_seen", 32'(exp_q.size()), 32'd0);
    chk_cur("reclear_cursor", 0, 0);
    check("reclear_err", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
